temporal_ngram_encoder: RTL and testbench
=========================================

# temporal_ngram_encoder

Downstream neighbour of the spatial encoder. Accepts the three per-modality spatial hypervectors and fuses them into one hypervector by bitwise 3-way majority. It then builds a temporal N-gram over a sliding window of the last NGRAM fused vectors, binding them by XOR of circularly rotated copies. The registered N-gram hypervector is presented to the associative-memory stage through a valid/ready handshake.

## Interface
- DIM, default `HV_DIMENSION: hypervector width; bit 0 is the leftmost bit (`[0:DIM-1]` indexing).
- NGRAM, default 3: window length, legal range 1..8.
- Clk_CI, input, 1: single clock, rising edge.
- Reset_RI, input, 1: asynchronous, active-high reset.
- ValidIn_SI, input, 1: upstream has a sample on the three modality inputs.
- ReadyOut_SO, output, 1: block accepts a sample this cycle.
- HypervectorIn_mod1_DI, input, DIM: modality 1 spatial hypervector.
- HypervectorIn_mod2_DI, input, DIM: modality 2 spatial hypervector.
- HypervectorIn_mod3_DI, input, DIM: modality 3 spatial hypervector.
- FlushIn_SI, input, 1: synchronous window clear.
- ValidOut_SO, output, 1: NGramOut_DO holds a valid N-gram.
- ReadyIn_SI, input, 1: downstream accepts the output.
- NGramOut_DO, output, DIM: registered N-gram hypervector.
- FillCnt_SO, output, `ceilLog2(NGRAM+1)`: number of window entries filled, saturating at NGRAM.

## Operation
- **Fusion:** F[i] = maj(mod1[i], mod2[i], mod3[i]). This is combinational on the inputs and sampled only on acceptance.
- **History:** registers H[0..NGRAM-1]. On acceptance, H[0] <= F and H[k] <= H[k-1]. FillCnt increments, saturating at NGRAM.
- **Rotation:** rot_k(x)[i] = x[(i-k) mod DIM]. Example with DIM=8: rot_1(8'h01) = 8'h80.
- **N-gram:** N = H[0] ^ rot_1(H[1]) ^ ... ^ rot_{NGRAM-1}(H[NGRAM-1]). H[0] is the newest entry.
- **FSM states:**
  - IDLE: ReadyOut_SO = 1. On ValidIn_SI, accept the sample. Go to FUSE if the updated FillCnt == NGRAM, otherwise stay in IDLE.
  - FUSE: NGramOut_DO <= N. Go to OUT. ReadyOut_SO = 0.
  - OUT: ValidOut_SO = 1 and ReadyOut_SO = 0. On ReadyIn_SI, go to IDLE.
- **Sliding window:** once the window is full, every accepted sample produces exactly one output.
- **Output stability:** NGramOut_DO changes only in FUSE and holds its value at all other times, including after the handshake.
- **Flush:** FlushIn_SI has priority over everything. It clears H, FillCnt and ValidOut_SO, leaves NGramOut_DO unchanged, and sets the state to IDLE. A sample presented in the same cycle is not accepted: ReadyOut_SO is forced to 0 while FlushIn_SI = 1. A pending output is dropped.
- **Reset:** asserting Reset_RI at any point aborts the operation immediately.

## Timing
- **Reset values:** state IDLE, H = 0, FillCnt_SO = 0, NGramOut_DO = 0, ValidOut_SO = 0. ReadyOut_SO = 0 while Reset_RI is high and 1 in the first cycle after release.
- **Latency:** a sample accepted at edge n that fills the window gives NGramOut_DO and ValidOut_SO valid after edge n+1.
- **Minimum interval:** 3 cycles per output when ValidIn_SI and ReadyIn_SI are held high.
- **Output handshake:** ValidOut_SO stays high until the edge where ReadyIn_SI = 1. That edge completes the transfer, and ReadyOut_SO rises in the following cycle.
- **Inputs ignored outside IDLE:** ValidIn_SI has no effect in FUSE or OUT, and the upstream must hold its data.
- **NGRAM = 1:** NGramOut_DO = F of the latest sample, and every accept produces an output.

## Configuration
- **Macro:** `NGRAM_TUMBLING_EN`
- **Defined:** a completed output handshake in OUT also clears FillCnt and H. Windows are non-overlapping, so one output is produced per NGRAM accepted samples.
- **Undefined (default):** sliding window as described above; H and FillCnt are untouched by the output handshake.

## Test plan
- **Majority fusion:** DIM=8, NGRAM=1; mod1 = F0, mod2 = CC, mod3 = AA, ValidIn_SI = 1 -> NGramOut_DO = 8'hE8 and ValidOut_SO = 1 after edge n+1.
- **Sliding window:** DIM=8, NGRAM=3; all modalities equal; samples 01, 02, 04 -> a single output 8'h45. Then sample 08 -> 8'h8A. No output after the first two samples; FillCnt_SO reads 1, 2, 3, 3.
- **Backpressure:** hold ReadyIn_SI = 0 for 5 cycles in OUT -> ValidOut_SO and NGramOut_DO stay stable and ReadyOut_SO = 0 throughout. ValidIn_SI pulses are ignored and H does not change.
- **Flush:** flush in OUT with ValidIn_SI = 1 -> next cycle ValidOut_SO = 0, FillCnt_SO = 0, no sample accepted. The following three samples 01, 02, 04 give 8'h45.
- **Async reset:** assert Reset_RI mid-cycle in FUSE -> all outputs go to reset values without a clock edge. After release, ReadyOut_SO = 1.
- **`NGRAM_TUMBLING_EN` defined:** samples 01, 02, 04, 08, 10, 20 -> exactly two outputs; the second is computed from 08, 10, 20 only.

Source files
------------

// File: rtl/temporal_ngram_encoder_if.sv
// Handshake and data bundle between the spatial encoder, the temporal N-gram
// encoder and the associative-memory stage.
`ifndef HV_DIMENSION
`define HV_DIMENSION 8
`endif

interface temporal_ngram_encoder_if #(
    parameter int DIM   = `HV_DIMENSION,
    parameter int NGRAM = 3
);
    localparam int CW = $clog2(NGRAM + 1);

    logic           ValidIn_SI;
    logic           ReadyOut_SO;
    logic [0:DIM-1] HypervectorIn_mod1_DI;
    logic [0:DIM-1] HypervectorIn_mod2_DI;
    logic [0:DIM-1] HypervectorIn_mod3_DI;
    logic           FlushIn_SI;
    logic           ValidOut_SO;
    logic           ReadyIn_SI;
    logic [0:DIM-1] NGramOut_DO;
    logic [CW-1:0]  FillCnt_SO;

    modport master (
        output ValidIn_SI, HypervectorIn_mod1_DI, HypervectorIn_mod2_DI,
               HypervectorIn_mod3_DI, FlushIn_SI, ReadyIn_SI,
        input  ReadyOut_SO, ValidOut_SO, NGramOut_DO, FillCnt_SO
    );

    modport slave (
        input  ValidIn_SI, HypervectorIn_mod1_DI, HypervectorIn_mod2_DI,
               HypervectorIn_mod3_DI, FlushIn_SI, ReadyIn_SI,
        output ReadyOut_SO, ValidOut_SO, NGramOut_DO, FillCnt_SO
    );
endinterface

// File: rtl/temporal_ngram_encoder.sv
// Majority-fuses three modality hypervectors and emits a rotate/XOR N-gram over the last NGRAM samples.
// Latency: output valid one cycle after the window-filling accept; backpressure holds the block in OUT.
// NGRAM_TUMBLING_EN: output handshake also clears the window (non-overlapping windows).
`ifndef HV_DIMENSION
`define HV_DIMENSION 8
`endif

module temporal_ngram_encoder #(
    parameter int DIM   = `HV_DIMENSION,
    parameter int NGRAM = 3
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    temporal_ngram_encoder_if.slave io
);
    localparam int            CW   = $clog2(NGRAM + 1);
    localparam logic [CW-1:0] FULL = CW'(NGRAM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FUSE = 2'd1,
        OUT  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [0:DIM-1] hist_q [NGRAM];
    logic [0:DIM-1] fused;
    logic [0:DIM-1] ngram_c;
    logic [0:DIM-1] ngram_q;
    logic [CW-1:0]  fill_q;
    logic [CW-1:0]  fill_nxt;
    logic           sample_acc;
    logic           ready_out;
    logic           valid_out;
    logic           win_clr;

    // rot_k(x)[i] = x[(i-k) mod DIM], with bit 0 the leftmost bit
    function automatic logic [0:DIM-1] rot(input logic [0:DIM-1] x, input int k);
        logic [0:DIM-1] r;
        for (int i = 0; i < DIM; i++) begin
            r[i] = x[((i - k) % DIM + DIM) % DIM];
        end
        return r;
    endfunction

    assign fused = (io.HypervectorIn_mod1_DI & io.HypervectorIn_mod2_DI)
                 | (io.HypervectorIn_mod1_DI & io.HypervectorIn_mod3_DI)
                 | (io.HypervectorIn_mod2_DI & io.HypervectorIn_mod3_DI);

    assign fill_nxt = (fill_q == FULL) ? FULL : fill_q + CW'(1);

    always_comb begin
        ngram_c = hist_q[0];
        for (int k = 1; k < NGRAM; k++) begin
            ngram_c = ngram_c ^ rot(hist_q[k], k);
        end
    end

`ifdef NGRAM_TUMBLING_EN
    assign win_clr = (state_q == OUT) && io.ReadyIn_SI;
`else
    assign win_clr = 1'b0;
`endif

    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ready_out  = 1'b0;
        valid_out  = 1'b0;
        sample_acc = 1'b0;
        case (state_q)
            IDLE: begin
                ready_out = 1'b1;
                if (io.ValidIn_SI) begin
                    sample_acc = 1'b1;
                    if (fill_nxt == FULL) state_d = FUSE;
                end
            end
            FUSE: state_d = OUT;
            OUT: begin
                valid_out = 1'b1;
                if (io.ReadyIn_SI) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over any accept or transfer in the same cycle
        if (io.FlushIn_SI) begin
            state_d    = IDLE;
            ready_out  = 1'b0;
            sample_acc = 1'b0;
        end
    end

    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            for (int k = 0; k < NGRAM; k++) hist_q[k] <= '0;
            fill_q  <= '0;
            ngram_q <= '0;
        end else if (io.FlushIn_SI) begin
            for (int k = 0; k < NGRAM; k++) hist_q[k] <= '0;
            fill_q <= '0;
        end else begin
            if (win_clr) begin
                for (int k = 0; k < NGRAM; k++) hist_q[k] <= '0;
                fill_q <= '0;
            end else if (sample_acc) begin
                hist_q[0] <= fused;
                for (int k = 1; k < NGRAM; k++) hist_q[k] <= hist_q[k-1];
                fill_q <= fill_nxt;
            end
            if (state_q == FUSE) ngram_q <= ngram_c;
        end
    end

    assign io.ReadyOut_SO = ready_out & ~Reset_RI;
    assign io.ValidOut_SO = valid_out;
    assign io.NGramOut_DO = ngram_q;
    assign io.FillCnt_SO  = fill_q;

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// Bench for temporal_ngram_encoder: DIM=8 instances with NGRAM=3 and NGRAM=1,
// checked against a queue-based reference of the fused-sample window.
module tb_temporal_ngram_encoder;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [7:0] hist_m [$];
    logic [7:0] outs [$];
    logic [7:0] last_out;

    temporal_ngram_encoder_if #(.DIM(8), .NGRAM(3)) b3 ();
    temporal_ngram_encoder_if #(.DIM(8), .NGRAM(1)) b1 ();

    temporal_ngram_encoder #(.DIM(8), .NGRAM(3)) dut3 (.Clk_CI(clk), .Reset_RI(rst), .io(b3));
    temporal_ngram_encoder #(.DIM(8), .NGRAM(1)) dut1 (.Clk_CI(clk), .Reset_RI(rst), .io(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] maj_m(input logic [7:0] a, b, c);
        logic [7:0] f;
        for (int i = 0; i < 8; i++) f[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
        return f;
    endfunction

    function automatic logic [7:0] rotr_m(input logic [7:0] x, input int k);
        if (k == 0) return x;
        return (x >> k) | (x << (8 - k));
    endfunction

    function automatic logic [7:0] ngram_m();
        logic [7:0] r;
        r = 8'h00;
        foreach (hist_m[k]) r = r ^ rotr_m(hist_m[k], k);
        return r;
    endfunction

    // One sample through the NGRAM=3 instance; hold = cycles of output backpressure
    task automatic send3(input logic [7:0] a, b, c, input int hold, input bit pulse);
        int         n;
        logic       out_exp;
        logic [7:0] exp;
        n = 0;
        while (b3.ReadyOut_SO !== 1'b1 && n < 20) begin step(); n++; end
        tests++;
        if (b3.ReadyOut_SO !== 1'b1) begin
            fails++; $display("FAIL ready_wait: ReadyOut=%b, required 1", b3.ReadyOut_SO);
        end
        b3.HypervectorIn_mod1_DI = a;
        b3.HypervectorIn_mod2_DI = b;
        b3.HypervectorIn_mod3_DI = c;
        b3.ValidIn_SI = 1'b1;
        step();
        b3.ValidIn_SI = 1'b0;
        hist_m.push_front(maj_m(a, b, c));
        if (hist_m.size() > 3) void'(hist_m.pop_back());
        out_exp = (hist_m.size() == 3);
        exp = ngram_m();
        tests++;
        if (b3.FillCnt_SO !== hist_m.size()) begin
            fails++; $display("FAIL fill_cnt: got %0d, required %0d", b3.FillCnt_SO, hist_m.size());
        end
        step();
        tests++;
        if (b3.ValidOut_SO !== out_exp) begin
            fails++; $display("FAIL valid_latency: got %b, required %b", b3.ValidOut_SO, out_exp);
        end
        if (out_exp) begin
            tests++;
            if (b3.NGramOut_DO !== exp) begin
                fails++; $display("FAIL ngram: got %h, required %h", b3.NGramOut_DO, exp);
            end
            for (int h = 0; h < hold; h++) begin
                if (pulse) begin
                    b3.ValidIn_SI = 1'($urandom_range(0, 1));
                    b3.HypervectorIn_mod1_DI = 8'($urandom);
                    b3.HypervectorIn_mod2_DI = 8'($urandom);
                    b3.HypervectorIn_mod3_DI = 8'($urandom);
                end
                step();
                tests++;
                if (b3.ValidOut_SO !== 1'b1 || b3.NGramOut_DO !== exp || b3.ReadyOut_SO !== 1'b0
                    || b3.FillCnt_SO !== hist_m.size()) begin
                    fails++;
                    $display("FAIL backpressure: v=%b d=%h r=%b f=%0d, required v=1 d=%h r=0 f=%0d",
                             b3.ValidOut_SO, b3.NGramOut_DO, b3.ReadyOut_SO, b3.FillCnt_SO,
                             exp, hist_m.size());
                end
            end
            b3.ValidIn_SI = 1'b0;
            b3.ReadyIn_SI = 1'b1;
            step();
            b3.ReadyIn_SI = 1'b0;
            tests++;
            if (b3.ReadyOut_SO !== 1'b1 || b3.ValidOut_SO !== 1'b0 || b3.NGramOut_DO !== exp) begin
                fails++;
                $display("FAIL handshake: r=%b v=%b d=%h, required r=1 v=0 d=%h",
                         b3.ReadyOut_SO, b3.ValidOut_SO, b3.NGramOut_DO, exp);
            end
            outs.push_back(exp);
            last_out = exp;
`ifdef NGRAM_TUMBLING_EN
            hist_m.delete();
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b3.ValidIn_SI = 0; b3.FlushIn_SI = 0; b3.ReadyIn_SI = 0;
        b3.HypervectorIn_mod1_DI = 0; b3.HypervectorIn_mod2_DI = 0; b3.HypervectorIn_mod3_DI = 0;
        b1.ValidIn_SI = 0; b1.FlushIn_SI = 0; b1.ReadyIn_SI = 0;
        b1.HypervectorIn_mod1_DI = 0; b1.HypervectorIn_mod2_DI = 0; b1.HypervectorIn_mod3_DI = 0;
        #3;
        tests++;
        if (b3.ReadyOut_SO !== 1'b0) begin
            fails++; $display("FAIL reset_ready_low: got %b, required 0", b3.ReadyOut_SO);
        end
        step(); step();
        rst = 1'b0;
        step();
        tests++;
        if (b3.ReadyOut_SO !== 1'b1 || b3.ValidOut_SO !== 1'b0 || b3.FillCnt_SO !== 2'd0
            || b3.NGramOut_DO !== 8'h00 || b1.ReadyOut_SO !== 1'b1) begin
            fails++;
            $display("FAIL reset_values: r=%b v=%b f=%0d d=%h r1=%b, required r=1 v=0 f=0 d=00 r1=1",
                     b3.ReadyOut_SO, b3.ValidOut_SO, b3.FillCnt_SO, b3.NGramOut_DO, b1.ReadyOut_SO);
        end
    endtask

    task automatic test_majority();
        b1.HypervectorIn_mod1_DI = 8'hF0;
        b1.HypervectorIn_mod2_DI = 8'hCC;
        b1.HypervectorIn_mod3_DI = 8'hAA;
        b1.ValidIn_SI = 1'b1;
        step();
        b1.ValidIn_SI = 1'b0;
        tests++;
        if (b1.ValidOut_SO !== 1'b0 || b1.FillCnt_SO !== 1'b1) begin
            fails++; $display("FAIL maj_fuse_cycle: v=%b f=%0d, required v=0 f=1", b1.ValidOut_SO, b1.FillCnt_SO);
        end
        step();
        tests++;
        if (b1.ValidOut_SO !== 1'b1 || b1.NGramOut_DO !== 8'hE8) begin
            fails++; $display("FAIL maj_out: v=%b d=%h, required v=1 d=e8", b1.ValidOut_SO, b1.NGramOut_DO);
        end
        b1.ReadyIn_SI = 1'b1;
        step();
        b1.ReadyIn_SI = 1'b0;
        tests++;
        if (b1.ReadyOut_SO !== 1'b1 || b1.ValidOut_SO !== 1'b0) begin
            fails++; $display("FAIL maj_handshake: r=%b v=%b, required r=1 v=0", b1.ReadyOut_SO, b1.ValidOut_SO);
        end
    endtask

    task automatic test_window();
        int         exp_cnt;
        logic [7:0] exp_second;
        logic [7:0] s [6];
`ifdef NGRAM_TUMBLING_EN
        exp_cnt = 2; exp_second = 8'h2A;
`else
        exp_cnt = 4; exp_second = 8'h8A;
`endif
        s = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
        outs.delete();
        foreach (s[i]) send3(s[i], s[i], s[i], 0, 0);
        tests++;
        if (outs.size() != exp_cnt) begin
            fails++; $display("FAIL window_count: got %0d outputs, required %0d", outs.size(), exp_cnt);
        end else begin
            tests++;
            if (outs[0] !== 8'h45 || outs[1] !== exp_second || outs[exp_cnt-1] !== 8'h2A) begin
                fails++;
                $display("FAIL window_values: got %h %h last %h, required 45 %h last 2a",
                         outs[0], outs[1], outs[exp_cnt-1], exp_second);
            end
        end
    endtask

    task automatic test_backpressure();
        send3(8'h11, 8'h13, 8'h31, 0, 0);
        send3(8'h5A, 8'h5A, 8'hFF, 0, 0);
        send3(8'h77, 8'h70, 8'h07, 5, 1);
        send3(8'h81, 8'h81, 8'h00, 0, 0);
    endtask

    task automatic test_flush();
        b3.FlushIn_SI = 1'b1;
        step();
        b3.FlushIn_SI = 1'b0;
        hist_m.delete();
        send3(8'h01, 8'h01, 8'h01, 0, 0);
        send3(8'h02, 8'h02, 8'h02, 0, 0);
        b3.HypervectorIn_mod1_DI = 8'h04; b3.HypervectorIn_mod2_DI = 8'h04; b3.HypervectorIn_mod3_DI = 8'h04;
        b3.ValidIn_SI = 1'b1;
        step();
        b3.ValidIn_SI = 1'b0;
        step();
        tests++;
        if (b3.ValidOut_SO !== 1'b1 || b3.NGramOut_DO !== 8'h45) begin
            fails++; $display("FAIL flush_setup: v=%b d=%h, required v=1 d=45", b3.ValidOut_SO, b3.NGramOut_DO);
        end
        b3.HypervectorIn_mod1_DI = 8'hFF; b3.HypervectorIn_mod2_DI = 8'hFF; b3.HypervectorIn_mod3_DI = 8'hFF;
        b3.ValidIn_SI = 1'b1;
        b3.FlushIn_SI = 1'b1;
        step();
        tests++;
        if (b3.ReadyOut_SO !== 1'b0) begin
            fails++; $display("FAIL flush_ready: got %b, required 0", b3.ReadyOut_SO);
        end
        b3.FlushIn_SI = 1'b0;
        b3.ValidIn_SI = 1'b0;
        tests++;
        if (b3.ValidOut_SO !== 1'b0 || b3.FillCnt_SO !== 2'd0 || b3.NGramOut_DO !== 8'h45) begin
            fails++; $display("FAIL flush_clear: v=%b f=%0d d=%h, required v=0 f=0 d=45",
                              b3.ValidOut_SO, b3.FillCnt_SO, b3.NGramOut_DO);
        end
        hist_m.delete();
        send3(8'h01, 8'h01, 8'h01, 0, 0);
        send3(8'h02, 8'h02, 8'h02, 0, 0);
        send3(8'h04, 8'h04, 8'h04, 0, 0);
        tests++;
        if (last_out !== 8'h45) begin
            fails++; $display("FAIL flush_refill: got %h, required 45", last_out);
        end
    endtask

    task automatic test_async_reset();
        b3.FlushIn_SI = 1'b1;
        step();
        b3.FlushIn_SI = 1'b0;
        hist_m.delete();
        send3(8'h01, 8'h01, 8'h01, 0, 0);
        send3(8'h02, 8'h02, 8'h02, 0, 0);
        b3.HypervectorIn_mod1_DI = 8'h04; b3.HypervectorIn_mod2_DI = 8'h04; b3.HypervectorIn_mod3_DI = 8'h04;
        b3.ValidIn_SI = 1'b1;
        step();
        b3.ValidIn_SI = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (b3.ReadyOut_SO !== 1'b0 || b3.ValidOut_SO !== 1'b0 || b3.FillCnt_SO !== 2'd0
            || b3.NGramOut_DO !== 8'h00) begin
            fails++; $display("FAIL async_reset: r=%b v=%b f=%0d d=%h, required r=0 v=0 f=0 d=00",
                              b3.ReadyOut_SO, b3.ValidOut_SO, b3.FillCnt_SO, b3.NGramOut_DO);
        end
        step();
        rst = 1'b0;
        #1;
        tests++;
        if (b3.ReadyOut_SO !== 1'b1) begin
            fails++; $display("FAIL reset_release_ready: got %b, required 1", b3.ReadyOut_SO);
        end
        step();
        tests++;
        if (b3.ValidOut_SO !== 1'b0) begin
            fails++; $display("FAIL reset_abort: ValidOut=%b, required 0", b3.ValidOut_SO);
        end
        hist_m.delete();
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            send3(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        last_out = 8'h00;
        test_reset();
        test_majority();
        test_window();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
